// File: rtl/apb_slave_regbank.sv
// APB slave with NUM_REGS read/write registers, programmable wait states and per-register write
// strobes. Define APB_REGBANK_SLVERR_EN to flag invalid accesses on pslverr.
module apb_slave_regbank #(
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
    parameter int unsigned          WAIT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [DATA_W-1:0]            pwdata,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int unsigned BYTE_SHIFT = $clog2(DATA_W / 8);
    localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << BYTE_SHIFT) - 1);
    localparam logic [3:0]  CNT_MAX    = 4'(WAIT_CYCLES);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   write_q, write_d;
    logic                   valid_q, valid_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_W-1:0]      prdata_q, prdata_d;
    logic [NUM_REGS-1:0]    wr_pulse_q, wr_pulse_d;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [DATA_W-1:0]      regs_d [NUM_REGS];

    logic [ADDR_W-1:0]      off;
    logic [ADDR_W-1:0]      idx_full;
    logic [IDX_W-1:0]       idx;
    logic                   valid;

    // Range check is done on the full-width index so high addresses never alias.
    always_comb begin
        off      = paddr - BASE_ADDR;
        idx_full = off >> BYTE_SHIFT;
        idx      = idx_full[IDX_W-1:0];
        valid    = ((off & ALIGN_MASK) == '0) && (idx_full < ADDR_W'(NUM_REGS));
    end

    assign pready = (state_q == StAccess) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        prdata_d   = prdata_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        unique case (state_q)
            StIdle: begin
                if (psel && !penable) begin
                    write_d  = pwrite;
                    valid_d  = valid;
                    idx_d    = idx;
                    prdata_d = (!pwrite && valid) ? regs_q[idx] : '0;
                    cnt_d    = '0;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                if (!(psel && penable)) begin
                    state_d = StIdle;
                end else if (pready) begin
                    if (write_q && valid_q) begin
                        regs_d[idx_q]     = pwdata;
                        wr_pulse_d[idx_q] = 1'b1;
                    end
                    state_d = StIdle;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign prdata   = (pready && !write_q) ? prdata_q : '0;
    assign wr_pulse = wr_pulse_q;

`ifdef APB_REGBANK_SLVERR_EN
    assign pslverr = pready & ~valid_q;
`else
    assign pslverr = 1'b0;
`endif

    for (genvar i = 0; i < NUM_REGS; i++) begin : gen_reg_out
        assign reg_q[i*DATA_W +: DATA_W] = regs_q[i];
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: three instances (0/2/3 wait states, one with a nonzero base)
// checked every cycle against a transaction-level model plus literal expectations.
module tb_apb_slave_regbank;

    localparam int N  = 3;
    localparam int NR = 8;
`ifdef APB_REGBANK_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic              psel [N];
    logic              penable [N];
    logic              pwrite [N];
    logic [31:0]       paddr [N];
    logic [31:0]       pwdata [N];
    logic [31:0]       prdata [N];
    logic              pready [N];
    logic              pslverr [N];
    logic [NR*32-1:0]  reg_q [N];
    logic [NR-1:0]     wr_pulse [N];

    apb_slave_regbank #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .BASE_ADDR(32'h0),
                        .WAIT_CYCLES(0)) u_d0 (
        .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .reg_q(reg_q[0]), .wr_pulse(wr_pulse[0]));
    apb_slave_regbank #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .BASE_ADDR(32'h40),
                        .WAIT_CYCLES(2)) u_d1 (
        .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .reg_q(reg_q[1]), .wr_pulse(wr_pulse[1]));
    apb_slave_regbank #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .BASE_ADDR(32'h0),
                        .WAIT_CYCLES(3)) u_d2 (
        .clk(clk), .rst(rst), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
        .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]), .pready(pready[2]),
        .pslverr(pslverr[2]), .reg_q(reg_q[2]), .wr_pulse(wr_pulse[2]));

    int          wc [N]   = '{0, 2, 3};
    logic [31:0] base [N] = '{32'h0, 32'h40, 32'h0};

    // Model: register contents, expected per-cycle outputs and a commit pending for next cycle.
    logic [31:0]   m_regs [N][NR];
    logic [NR-1:0] m_pulse [N];
    logic          m_pready [N];
    logic [31:0]   m_prdata [N];
    logic          m_slverr [N];
    bit            pend_v [N];
    int            pend_i [N];
    logic [31:0]   pend_dat [N];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NR*32-1:0] flat(input int d);
        logic [NR*32-1:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = m_regs[d][i];
        return f;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < N; d++) begin
                check($sformatf("d%0d reg_q", d), reg_q[d], flat(d));
                check($sformatf("d%0d wr_pulse", d), wr_pulse[d], m_pulse[d]);
                check($sformatf("d%0d pready", d), pready[d], m_pready[d]);
                check($sformatf("d%0d prdata", d), prdata[d], m_prdata[d]);
                check($sformatf("d%0d pslverr", d), pslverr[d], m_slverr[d]);
            end
        end
    end

    task automatic clear_model();
        for (int d = 0; d < N; d++) begin
            for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
            m_pulse[d] = '0;
            pend_v[d]  = 1'b0;
        end
    endtask

    // Advance one cycle: apply last cycle's commit to the model, idle every bus.
    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            if (pend_v[d]) begin
                m_regs[d][pend_i[d]] = pend_dat[d];
                m_pulse[d] = NR'(1) << pend_i[d];
                pend_v[d]  = 1'b0;
            end else begin
                m_pulse[d] = '0;
            end
            m_pready[d] = 1'b0;
            m_prdata[d] = '0;
            m_slverr[d] = 1'b0;
            psel[d]     = 1'b0;
            penable[d]  = 1'b0;
            pwrite[d]   = 1'b0;
            paddr[d]    = '0;
            pwdata[d]   = '0;
        end
    endtask

    task automatic do_reset(input int n);
        step();
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            clear_model();
            if (i == n - 1) rst = 1'b0;
        end
    endtask

    // One APB transfer; abort_at = k drops penable in access cycle k (k < wait cycles).
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int abort_at,
                        output logic [31:0] rd, output bit err, output int len);
        logic [31:0] off;
        bit          valid;
        logic [31:0] rv;
        off   = addr - base[d];
        valid = (off % 4 == 0) && (off / 4 < NR);
        rd = '0; err = 1'b0; len = 0;
        step();
        psel[d] = 1'b1; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = ~data;
        rv = (!wr && valid) ? m_regs[d][off[4:2]] : 32'h0;
        for (int k = 0; k <= wc[d]; k++) begin
            step();
            psel[d] = 1'b1; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
            if (k == abort_at) break;
            penable[d] = 1'b1;
            if (k == wc[d]) begin
                m_pready[d] = 1'b1;
                m_prdata[d] = rv;
                m_slverr[d] = SLV && !valid;
                if (wr && valid) begin
                    pend_v[d]   = 1'b1;
                    pend_i[d]   = int'(off[4:2]);
                    pend_dat[d] = data;
                end
            end
            #1;
            if (pready[d] && len == 0) begin
                len = k + 2;
                rd  = prdata[d];
                err = pslverr[d];
            end
        end
    endtask

    logic [31:0] rd;
    bit          err;
    int          len;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < N; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
            m_pready[d] = 1'b0; m_prdata[d] = '0; m_slverr[d] = 1'b0;
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Reset: populate a register, then reset in the middle of a wait-stated write to reg 3.
        xfer(1, 1'b1, 32'h54, 32'h0000_00A5, -1, rd, err, len);
        check("d1 write len", 32'(len), 32'd4);
        step();
        check("d1 reg5 written", reg_q[1][191:160], 32'hA5);
        step();
        psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h4C;
        step();
        psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h4C;
        pwdata[1] = 32'h1234_5678;
        do_reset(2);
        check("rst reg_q", reg_q[1], '0);
        check("rst reg3", reg_q[1][127:96], 32'h0);
        check("rst pready", pready[1], 1'b0);
        check("rst wr_pulse", wr_pulse[1], 8'h00);
        step();

        // Zero wait states: write then read back.
        xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, -1, rd, err, len);
        check("zw write len", 32'(len), 32'd2);
        check("zw write err", err, 1'b0);
        step();
        check("zw wr_pulse", wr_pulse[0], 8'h04);
        check("zw reg2", reg_q[0][95:64], 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h08, 32'h0, -1, rd, err, len);
        check("zw read data", rd, 32'hDEAD_BEEF);
        check("zw read err", err, 1'b0);

        // Wait states: read 0x00 with three extra cycles, then a round trip on reg 7.
        xfer(2, 1'b0, 32'h00, 32'h0, -1, rd, err, len);
        check("ws read len", 32'(len), 32'd5);
        check("ws read data", rd, 32'h0);
        xfer(2, 1'b1, 32'h1C, 32'hCAFE_F00D, -1, rd, err, len);
        xfer(2, 1'b0, 32'h1C, 32'h0, -1, rd, err, len);
        check("ws read reg7", rd, 32'hCAFE_F00D);

        // Invalid accesses: out of range, misaligned, above range, below base.
        xfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, -1, rd, err, len);
        check("err write 0x20", err, SLV);
        xfer(0, 1'b0, 32'h02, 32'h0, -1, rd, err, len);
        check("err read 0x02 err", err, SLV);
        check("err read 0x02 data", rd, 32'h0);
        xfer(0, 1'b1, 32'h1000_0008, 32'h1111_1111, -1, rd, err, len);
        check("err alias err", err, SLV);
        xfer(1, 1'b1, 32'h3C, 32'h2222_2222, -1, rd, err, len);
        check("err below base", err, SLV);
        step();
        check("err reg2 kept", reg_q[0][95:64], 32'hDEAD_BEEF);

        // Abort during wait states, then back-to-back writes and an immediate read.
        xfer(1, 1'b1, 32'h40, 32'h55, 1, rd, err, len);
        check("abort no pready", 32'(len), 32'd0);
        step();
        check("abort reg0", reg_q[1][31:0], 32'h0);
        xfer(1, 1'b1, 32'h40, 32'h1, -1, rd, err, len);
        xfer(1, 1'b1, 32'h44, 32'h2, -1, rd, err, len);
        xfer(1, 1'b0, 32'h44, 32'h0, -1, rd, err, len);
        check("b2b read reg1", rd, 32'h2);
        check("b2b regs", reg_q[1][63:0], 64'h0000_0002_0000_0001);
        xfer(0, 1'b1, 32'h00, 32'h0000_0011, -1, rd, err, len);
        xfer(0, 1'b0, 32'h00, 32'h0, -1, rd, err, len);
        check("zw b2b read reg0", rd, 32'h11);

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
# apb_slave_regbank

Parametrised APB slave endpoint with a bank of `NUM_REGS` read/write registers, programmable wait states and error response. It replaces fixed-width, zero-wait APB slave hookups on the APB side of the ICB-to-APB crypto bridge. It exposes the register contents and per-register write strobes to downstream logic such as key, IV and control registers of the crypto engine.

## Interface
Parameters:
- `ADDR_W`, 32, APB address width.
- `DATA_W`, 32, APB data/register width; must be 8, 16, 32 or 64.
- `NUM_REGS`, 8, number of registers; must be at least 1.
- `BASE_ADDR`, 0, byte address of register 0; must be aligned to `DATA_W/8`.
- `WAIT_CYCLES`, 0, extra access-phase cycles before `pready`, in the range 0..15.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `psel` in 1: APB select.
- `penable` in 1: APB enable (access phase).
- `pwrite` in 1: 1 for write, 0 for read.
- `paddr` in `ADDR_W`: byte address.
- `pwdata` in `DATA_W`: write data.
- `prdata` out `DATA_W`: read data; valid when `pready` is high.
- `pready` out 1: transfer completes in this cycle.
- `pslverr` out 1: error response; valid only when `pready` is high.
- `reg_q` out `NUM_REGS*DATA_W`: flat register contents; register i occupies bits [i*DATA_W +: DATA_W].
- `wr_pulse` out `NUM_REGS`: one-cycle strobe per register after a committed write.

## Operation
- Address decode:
  - `off = paddr - BASE_ADDR`, computed modulo 2^`ADDR_W`.
  - `idx = off >> log2(DATA_W/8)`.
  - The access is valid when `off` is aligned and `idx < NUM_REGS`; otherwise it is invalid.
- The FSM has two states, IDLE and ACCESS, plus a 4-bit wait counter `cnt`.
- In IDLE:
  - When `psel=1` and `penable=0` (setup phase), latch `pwrite`, `idx` and `valid`.
  - On a read, also latch `prdata_q = reg[idx]`, or 0 if the access is invalid.
  - Then go to ACCESS with `cnt=0`.
- In ACCESS:
  - `pready = (cnt == WAIT_CYCLES)`. This is combinational from the state and `cnt`, so with `WAIT_CYCLES=0` the transfer has zero wait states.
  - While `pready=0`, `cnt` increments every cycle.
  - At the edge where `psel & penable & pready` is true, a valid write commits: `reg[idx] <= pwdata`, and `wr_pulse[idx]` goes high for exactly the next cycle. The state then returns to IDLE.
  - `pwdata` is sampled at the commit edge, not at setup.
  - The next setup phase may occur in the cycle immediately after completion (back-to-back transfers).
- Protocol abort: if `psel=0` or `penable=0` in ACCESS before `pready`, return to IDLE. No write is committed and no `wr_pulse` is issued.
- `prdata` equals `prdata_q` while in ACCESS with `pready=1` on a read, and 0 otherwise.
- Arithmetic: `cnt` saturates at `WAIT_CYCLES`. `idx` comparisons are done at full `ADDR_W` width, so there is no aliasing above `NUM_REGS`.

## Timing
- Reset values (applied at the rising edge with `rst=1`):
  - All registers 0, so `reg_q` = 0.
  - `wr_pulse` = 0, `prdata` = 0, `pready` = 0, `pslverr` = 0.
  - FSM in IDLE, `cnt` = 0.
- Reset during ACCESS aborts the transfer. Any write that has not yet committed is dropped, and `pready` is 0 in the cycle after reset.
- Transfer length, counted from the setup cycle to the completion cycle, is `2 + WAIT_CYCLES` cycles.
- `reg_q` reflects a write one cycle after the commit edge, in the same cycle that `wr_pulse` is high.
- A read in the setup cycle that coincides with a `wr_pulse` cycle returns the new value.

## Configuration
- Macro: `APB_REGBANK_SLVERR_EN`.
- Defined:
  - `pslverr = pready & ~valid` for the latched access.
  - Invalid writes are ignored; invalid reads return 0.
- Undefined:
  - `pslverr` is tied to 0.
  - Invalid accesses complete normally: writes are ignored and reads return 0.
  - The `valid` latch is still used to gate writes.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-write to register 3 with `WAIT_CYCLES=2` → `reg_q`=0, `pready`=0 and `wr_pulse`=0 after reset; register 3 stays 0.
- **Zero-wait write then read:** with `WAIT_CYCLES=0`, write 0xDEADBEEF to 0x08 → `pready` is high in the second cycle, `wr_pulse[2]` pulses once, `reg_q[95:64]`=0xDEADBEEF. Reading 0x08 returns 0xDEADBEEF with `pslverr`=0.
- **Wait states:** with `WAIT_CYCLES=3`, read 0x00 → `pready` is low for 3 access cycles and high on the 4th; the transfer takes 5 cycles in total.
- **Error:** with the macro defined, write to 0x20 (`NUM_REGS=8`) and read 0x02 (misaligned) → `pslverr`=1 with `pready`, no register changes, read data is 0. Without the macro, `pslverr`=0 for the same accesses.
- **Abort and back-to-back:** drop `penable` during wait states of a write of 0x55 → no commit. Then issue back-to-back writes of 0x1 and 0x2 to registers 0 and 1 → both commit, with `wr_pulse` high on consecutive transfers.
